trigger_frame_scheduler: RTL and testbench

TRIGGER_FRAME_SCHEDULER -- requirements
Module: trigger_frame_scheduler

---
 rtl/trigger_frame_scheduler.sv | 177 +++++++++++++++++
 tb/tb_trigger_frame_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_frame_scheduler.sv
// trigger_frame_scheduler
//   Arbitrates two trigger requesters and serialises each grant into a
//   7-byte frame for an 8b10b encoder:
//     SOF(K27.7) HDR CODE TSH TSL CRC EOF(K29.7)
//   Idle commas (K28.5) are sent between frames.
//   A programmable minimum idle gap separates EOF from the next SOF.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   ena               : allows a new frame to start (never aborts one)
//   req[1:0]          : per-requester request, held until acked
//   code0/1, ts0/1    : per-requester event code and 16-bit timestamp
//   ack[1:0]          : one-cycle grant pulse, coincident with SOF
//   tx_data, tx_k     : registered byte and K flag to the encoder
//   busy              : high SOF..EOF inclusive
//   frame_done        : one-cycle pulse coincident with EOF
module trigger_frame_scheduler #(
    parameter logic [7:0] POLYNOMIAL = 8'h07,
    parameter int         MIN_IDLE   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic [1:0]  req,
    input  logic [7:0]  code0,
    input  logic [7:0]  code1,
    input  logic [15:0] ts0,
    input  logic [15:0] ts1,
    output logic [1:0]  ack,
    output logic [7:0]  tx_data,
    output logic        tx_k,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_HDR, S_CODE, S_TSH, S_TSL, S_CRC, S_EOF
    } state_t;

    localparam logic [3:0] GAP_MAX = 4'(MIN_IDLE);

    state_t      state_q, state_d;
    logic [3:0]  seq_q, seq_d;
    logic [3:0]  gap_q, gap_d;
    logic        last_q, last_d;   // index granted most recently
    logic        src_q, src_d;
    logic [7:0]  code_q, code_d;
    logic [15:0] ts_q, ts_d;
    logic [7:0]  crc_q, crc_d;
    logic [1:0]  ack_q, ack_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_k_q, tx_k_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        winner;
    logic        gap_ok;
    logic        start;

    // One MSB-first CRC-8 byte update, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ POLYNOMIAL) : (c << 1);
        end
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        gap_d     = gap_q;
        last_d    = last_q;
        src_d     = src_q;
        code_d    = code_q;
        ts_d      = ts_q;
        crc_d     = crc_q;
        ack_d     = 2'b00;
        tx_data_d = 8'h00;
        tx_k_d    = 1'b0;

        // Tie goes to whoever was not granted last; a lone request always wins.
        winner = (req == 2'b11) ? ~last_q : req[1];
        // The current idle cycle counts toward the gap, so a saturated count of
        // MIN_IDLE-1 already permits SOF on the next cycle.
        gap_ok = ({1'b0, gap_q} + 5'd1) >= {1'b0, GAP_MAX};
        start  = (state_q == S_IDLE) && ena && (req != 2'b00) && gap_ok;

        case (state_q)
            S_IDLE: if (start) state_d = S_SOF;
            S_SOF:  state_d = S_HDR;
            S_HDR:  state_d = S_CODE;
            S_CODE: state_d = S_TSH;
            S_TSH:  state_d = S_TSL;
            S_TSL:  state_d = S_CRC;
            S_CRC:  state_d = S_EOF;
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_EOF) begin
            gap_d = 4'd0;
            seq_d = seq_q + 4'd1;
        end else if (state_q == S_IDLE && gap_q < GAP_MAX) begin
            gap_d = gap_q + 4'd1;
        end

        if (start) begin
            src_d  = winner;
            last_d = winner;
            code_d = winner ? code1 : code0;
            ts_d   = winner ? ts1 : ts0;
            ack_d  = winner ? 2'b10 : 2'b01;
        end

        // CRC folds in each payload byte the cycle after it is on the wire.
        if (state_q == S_SOF)
            crc_d = 8'h00;
        else if (state_q inside {S_HDR, S_CODE, S_TSH, S_TSL})
            crc_d = crc8_step(crc_q, tx_data_q);

        // Outputs are registered from the next state so each cycle shows
        // the byte of the state it is in.
        case (state_d)
            S_IDLE: begin tx_data_d = 8'hBC; tx_k_d = 1'b1; end
            S_SOF:  begin tx_data_d = 8'hFB; tx_k_d = 1'b1; end
            S_HDR:  tx_data_d = {3'b000, src_q, seq_q};
            S_CODE: tx_data_d = code_q;
            S_TSH:  tx_data_d = ts_q[15:8];
            S_TSL:  tx_data_d = ts_q[7:0];
            S_CRC:  tx_data_d = crc_d;
            default: begin tx_data_d = 8'hFD; tx_k_d = 1'b1; end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_EOF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            seq_q     <= 4'd0;
            gap_q     <= GAP_MAX;
            last_q    <= 1'b1;
            src_q     <= 1'b0;
            code_q    <= 8'h00;
            ts_q      <= 16'h0000;
            crc_q     <= 8'h00;
            ack_q     <= 2'b00;
            tx_data_q <= 8'hBC;
            tx_k_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            gap_q     <= gap_d;
            last_q    <= last_d;
            src_q     <= src_d;
            code_q    <= code_d;
            ts_q      <= ts_d;
            crc_q     <= crc_d;
            ack_q     <= ack_d;
            tx_data_q <= tx_data_d;
            tx_k_q    <= tx_k_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ack        = ack_q;
    assign tx_data    = tx_data_q;
    assign tx_k       = tx_k_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_trigger_frame_scheduler.sv
module tb_trigger_frame_scheduler;

    localparam logic [7:0] POLY     = 8'h07;
    localparam int         MIN_IDLE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ena = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [7:0]  code0 = 8'h00, code1 = 8'h00;
    logic [15:0] ts0 = 16'h0000, ts1 = 16'h0000;
    logic [1:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_k, busy, frame_done;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    trigger_frame_scheduler #(.POLYNOMIAL(POLY), .MIN_IDLE(MIN_IDLE)) dut (
        .clk(clk), .reset(reset), .ena(ena), .req(req),
        .code0(code0), .code1(code1), .ts0(ts0), .ts1(ts1),
        .ack(ack), .tx_data(tx_data), .tx_k(tx_k), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Inputs as seen by the DUT at the most recent rising edge.
    logic        s_rst, s_ena;
    logic [1:0]  s_req;
    logic [7:0]  s_c0, s_c1;
    logic [15:0] s_t0, s_t1;
    bit          have_snap = 0;

    initial forever begin
        @(posedge clk);
        s_rst = reset; s_ena = ena; s_req = req;
        s_c0 = code0; s_c1 = code1; s_t0 = ts0; s_t1 = ts1;
        cyc++;
        have_snap = 1;
    end

    // Frame = sequence of bytes; position -1 means idle.
    int         m_pos  = -1;
    int         m_c    = 0;
    int         m_eof  = -1000;   // cycle index of the last EOF
    int         m_last = 1;
    int         m_seq  = 0;
    logic [1:0] m_ack  = 2'b00;
    logic [7:0] m_fr [7];

    // CRC as remainder of polynomial long division of msg*x^8 by x^8+POLY.
    function automatic logic [7:0] ref_crc(input logic [31:0] msg);
        logic [39:0] r;
        r = {msg, 8'h00};
        for (int i = 39; i >= 8; i--)
            if (r[i]) r[i -: 9] = r[i -: 9] ^ {1'b1, POLY};
        return r[7:0];
    endfunction

    task automatic model_step();
        int         win;
        logic [7:0] hdr, cd;
        logic [15:0] ts;
        m_c++;
        if (s_rst) begin
            m_pos = -1; m_eof = -1000; m_last = 1; m_seq = 0; m_ack = 2'b00;
        end else begin
            m_ack = 2'b00;
            if (m_pos < 0) begin
                if (s_ena && s_req != 2'b00 && (m_c - m_eof) >= MIN_IDLE + 1) begin
                    if (s_req == 2'b11) win = 1 - m_last;
                    else win = (s_req == 2'b10) ? 1 : 0;
                    hdr = {3'b000, 1'(win), 4'(m_seq)};
                    cd  = (win == 1) ? s_c1 : s_c0;
                    ts  = (win == 1) ? s_t1 : s_t0;
                    m_fr[0] = 8'hFB; m_fr[1] = hdr; m_fr[2] = cd;
                    m_fr[3] = ts[15:8]; m_fr[4] = ts[7:0];
                    m_fr[5] = ref_crc({hdr, cd, ts}); m_fr[6] = 8'hFD;
                    m_last = win;
                    m_ack  = (win == 1) ? 2'b10 : 2'b01;
                    m_pos  = 0;
                end
            end else if (m_pos == 6) begin
                m_eof = m_c - 1;
                m_seq = (m_seq + 1) % 16;
                m_pos = -1;
            end else begin
                m_pos++;
            end
        end
    endtask

    initial forever begin
        logic [7:0] e_tx;
        logic       e_k, e_busy, e_done;
        @(negedge clk);
        if (have_snap) begin
            model_step();
            if (m_pos < 0) begin
                e_tx = 8'hBC; e_k = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            end else begin
                e_tx = m_fr[m_pos]; e_k = (m_pos == 0 || m_pos == 6);
                e_busy = 1'b1; e_done = (m_pos == 6);
            end
            check("model {ack,tx,k,busy,done}",
                  32'({ack, tx_data, tx_k, busy, frame_done}),
                  32'({m_ack, e_tx, e_k, e_busy, e_done}));
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [1:0]       req;
        logic [7:0]       code;
        logic [15:0]      ts;
        logic [1:0]       ack;
        logic [6:0][7:0]  bytes;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] r, input logic [7:0] c, input logic [15:0] t,
                                input logic [1:0] a, input logic [7:0] b1, input logic [7:0] b5);
        vec_t v;
        v.req = r; v.code = c; v.ts = t; v.ack = a;
        v.bytes = {8'hFD, b5, t[7:0], t[15:8], c, b1, 8'hFB};
        return v;
    endfunction

    task automatic wait_ack(output logic [1:0] a, output bit ok);
        ok = 0; a = 2'b00;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                a = ack; ok = 1;
                return;
            end
        end
        check("ack_timeout", 32'd0, 32'd1);
    endtask

    vec_t vecs [3];

    initial begin
        logic [1:0] a;
        bit         ok;
        int         gcyc [4];
        logic [1:0] rr_exp [4];
        bit         got;

        vecs[0] = mk(2'b01, 8'h00, 16'h0001, 2'b01, 8'h00, 8'h07);
        vecs[1] = mk(2'b01, 8'h00, 16'h0000, 2'b01, 8'h01, 8'h16);
        vecs[2] = mk(2'b01, 8'h00, 16'h0000, 2'b01, 8'h02, 8'h2C);
        rr_exp[0] = 2'b10; rr_exp[1] = 2'b01; rr_exp[2] = 2'b10; rr_exp[3] = 2'b01;

        reset = 1'b1; ena = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", 32'({ack, tx_data, tx_k, busy, frame_done}),
              32'({2'b00, 8'hBC, 1'b1, 1'b0, 1'b0}));
        reset = 1'b0;

        // Table: known frames with hand-computed CRCs.
        for (int v = 0; v < 3; v++) begin
            req = vecs[v].req; code0 = vecs[v].code; ts0 = vecs[v].ts;
            code1 = vecs[v].code; ts1 = vecs[v].ts;
            wait_ack(a, ok);
            if (ok) begin
                req = 2'b00;
                check("vec_ack", 32'(a), 32'(vecs[v].ack));
                for (int i = 0; i < 7; i++) begin
                    if (i > 0) @(negedge clk);
                    check($sformatf("vec%0d_byte%0d", v, i), 32'({tx_k, tx_data}),
                          32'({(i == 0 || i == 6), vecs[v].bytes[i]}));
                end
            end
        end

        // Both requesting continuously: alternating grants 9 cycles apart.
        code0 = 8'h5A; ts0 = 16'h1234; code1 = 8'hA5; ts1 = 16'hBEEF;
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_ack(a, ok);
            gcyc[g] = cyc;
            check("rr_grant", 32'(a), 32'(rr_exp[g]));
            if (g > 0) check("rr_spacing", 32'(gcyc[g] - gcyc[g-1]), 32'(7 + MIN_IDLE));
        end
        req = 2'b00;

        // Sequence counter wrap over 17 frames.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        code0 = 8'h11; ts0 = 16'h2233; req = 2'b01;
        for (int f = 0; f < 17; f++) begin
            wait_ack(a, ok);
            @(negedge clk);
            check("hdr_seq", 32'(tx_data), 32'({4'h0, 4'(f % 16)}));
        end
        req = 2'b00;

        // ena dropped mid-frame: frame completes, pending request waits.
        @(negedge clk);
        req = 2'b01;
        wait_ack(a, ok);
        req = 2'b00;
        repeat (3) @(negedge clk);
        ena = 1'b0; req = 2'b10; code1 = 8'h77; ts1 = 16'h8001;
        repeat (3) @(negedge clk);
        check("eof_with_ena_low", 32'({tx_k, tx_data, frame_done}), 32'({1'b1, 8'hFD, 1'b1}));
        got = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack != 2'b00) got = 1;
        end
        check("no_ack_while_ena_low", 32'(got), 32'd0);
        ena = 1'b1;
        @(negedge clk);
        check("ack_after_ena", 32'(ack), 32'(2'b10));
        req = 2'b00;

        // Reset during CODE abandons the frame.
        repeat (12) @(negedge clk);
        req = 2'b01;
        wait_ack(a, ok);
        req = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_frame", 32'({ack, tx_data, tx_k, busy, frame_done}),
              32'({2'b00, 8'hBC, 1'b1, 1'b0, 1'b0}));
        reset = 1'b0;
        req = 2'b11;
        wait_ack(a, ok);
        req = 2'b00;
        check("first_tie_after_reset", 32'(a), 32'(2'b01));
        @(negedge clk);
        check("hdr_after_reset", 32'(tx_data), 32'(8'h00));

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            ena   = ($urandom_range(0, 9) != 0);
            if (req[0] && ack[0]) req[0] = 1'b0;
            else if (!req[0] && $urandom_range(0, 2) == 0) begin
                code0 = 8'($urandom); ts0 = 16'($urandom); req[0] = 1'b1;
            end
            if (req[1] && ack[1]) req[1] = 1'b0;
            else if (!req[1] && $urandom_range(0, 2) == 0) begin
                code1 = 8'($urandom); ts1 = 16'($urandom); req[1] = 1'b1;
            end
        end
        reset = 1'b0; req = 2'b00;
        repeat (20) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
